// File: rtl/temporizador_regressivo_pkg.sv
// Shared types for the count-down game timer: state encoding and its width.
package temporizador_regressivo_pkg;

    localparam int unsigned ESTADO_W = 2;

    typedef enum logic [ESTADO_W-1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } estado_t;

endpackage

// File: rtl/temporizador_regressivo_gerador_tick.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and pulses tick_o on the wrap cycle.
// Holds its value while disabled, so a paused count resumes mid time unit.
module gerador_tick #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] CNT_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/temporizador_regressivo.sv
// Programmable down-counting game timer with pause/resume, borrow-out level
// and a registered one-cycle expiry pulse.
module temporizador_regressivo
    import temporizador_regressivo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 50
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [WIDTH-1:0]    D,
    input  logic                start,
    input  logic                pause,
    output logic [WIDTH-1:0]    Q,
    output logic                rbo,
    output logic                tick,
    output logic                fim,
    output logic                running,
    output logic [ESTADO_W-1:0] estado
);

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             fim_q, fim_d;
    logic             presc_en;
    logic             presc_tick;

    // Gated here (not in the FSM process) so tick never feeds back into its own enable.
    assign presc_en = (state_q == ST_RUNNING) && !pause && !load && !reset
                      && (q_q != '0);

    gerador_tick #(
        .PRESCALE (PRESCALE)
    ) u_gerador_tick (
        .clk_i    (clock),
        .rst_i    (reset),
        .clear_i  (load),
        .enable_i (presc_en),
        .tick_o   (presc_tick)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        fim_d   = 1'b0;
        if (load) begin
            q_d     = D;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !pause && (q_q != '0)) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (presc_tick) begin
                        q_d = q_q - 1'b1;
                        if (q_q == WIDTH'(1)) begin
                            state_d = ST_EXPIRED;
                            fim_d   = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start && !pause) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            fim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            fim_q   <= fim_d;
        end
    end

    assign Q       = q_q;
    assign rbo     = (q_q == '0);
    assign tick    = presc_tick;
    assign fim     = fim_q;
    assign running = (state_q == ST_RUNNING);
    assign estado  = state_q;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Directed bench for the count-down timer with WIDTH=4, PRESCALE=4.
module tb_temporizador_regressivo;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned PRESCALE = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             load  = 1'b0;
    logic [WIDTH-1:0] D     = '0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             rbo;
    logic             tick;
    logic             fim;
    logic             running;
    logic [1:0]       estado;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    temporizador_regressivo #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .D       (D),
        .start   (start),
        .pause   (pause),
        .Q       (Q),
        .rbo     (rbo),
        .tick    (tick),
        .fim     (fim),
        .running (running),
        .estado  (estado)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset state
        #1;
        do_reset();
        check_eq("rst_Q", Q, 0);
        check_eq("rst_rbo", rbo, 1);
        check_eq("rst_estado", estado, 0);
        check_eq("rst_tick", tick, 0);
        check_eq("rst_fim", fim, 0);
        check_eq("rst_running", running, 0);

        // 2: full run from 3
        load = 1'b1; D = 4'd3;
        step();
        load = 1'b0;
        check_eq("s2_load_Q", Q, 3);
        check_eq("s2_load_rbo", rbo, 0);
        start = 1'b1;
        step();
        check_eq("s2_entry_estado", estado, 1);
        check_eq("s2_entry_running", running, 1);
        check_eq("s2_entry_tick", tick, 0);
        for (int k = 1; k <= 13; k++) begin
            step();
            check_eq($sformatf("s2_Q_%0d", k), Q, (k >= 12) ? 0 : 3 - k / 4);
            check_eq($sformatf("s2_tick_%0d", k), tick, ((k % 4 == 3) && k < 12) ? 1 : 0);
            check_eq($sformatf("s2_fim_%0d", k), fim, (k == 12) ? 1 : 0);
            check_eq($sformatf("s2_estado_%0d", k), estado, (k >= 12) ? 3 : 1);
        end
        check_eq("s2_rbo", rbo, 1);
        start = 1'b0;

        // 3: pause mid time unit and resume
        load = 1'b1; D = 4'd5;
        step();
        load = 1'b0;
        check_eq("s3_load_Q", Q, 5);
        check_eq("s3_load_estado", estado, 0);
        start = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) step();
        check_eq("s3_run_Q", Q, 4);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("s3_pQ_%0d", i), Q, 4);
            check_eq($sformatf("s3_pest_%0d", i), estado, 2);
            check_eq($sformatf("s3_ptick_%0d", i), tick, 0);
        end
        pause = 1'b0;
        step();
        check_eq("s3_resume_estado", estado, 1);
        check_eq("s3_resume_tick", tick, 0);
        step();
        check_eq("s3_tick_after2", tick, 1);
        check_eq("s3_Q_before_dec", Q, 4);
        step();
        check_eq("s3_Q_after_dec", Q, 3);
        check_eq("s3_tick_clear", tick, 0);
        start = 1'b0;

        // 4: start with Q==0 is ignored
        do_reset();
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq($sformatf("s4_estado_%0d", i), estado, 0);
            check_eq($sformatf("s4_tick_%0d", i), tick, 0);
            check_eq($sformatf("s4_fim_%0d", i), fim, 0);
        end
        start = 1'b0;

        // 5: load wins over start, then reload mid-run
        load = 1'b1; D = 4'd2; start = 1'b1;
        step();
        load = 1'b0;
        check_eq("s5_ldst_Q", Q, 2);
        check_eq("s5_ldst_estado", estado, 0);
        step();
        check_eq("s5_run_estado", estado, 1);
        step();
        step();
        load = 1'b1; D = 4'd7;
        step();
        load = 1'b0;
        check_eq("s5_reload_Q", Q, 7);
        check_eq("s5_reload_estado", estado, 0);
        check_eq("s5_reload_fim", fim, 0);
        step();
        check_eq("s5_rerun_estado", estado, 1);
        check_eq("s5_rerun_Q", Q, 7);
        check_eq("s5_rerun_fim", fim, 0);
        for (int k = 1; k <= 4; k++) step();
        check_eq("s5_first_dec", Q, 6);
        start = 1'b0;

        // 6: reset while Q==1 and prescaler on its wrap cycle
        load = 1'b1; D = 4'd1;
        step();
        load = 1'b0; start = 1'b1;
        step();
        step(); step(); step();
        check_eq("s6_pre_tick", tick, 1);
        check_eq("s6_pre_Q", Q, 1);
        reset = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        check_eq("s6_Q", Q, 0);
        check_eq("s6_estado", estado, 0);
        check_eq("s6_fim", fim, 0);
        step();
        check_eq("s6_fim_next", fim, 0);
        check_eq("s6_tick_next", tick, 0);

        // 7: load on the expiring edge suppresses fim
        load = 1'b1; D = 4'd1;
        step();
        load = 1'b0; start = 1'b1;
        step();
        step(); step(); step();
        check_eq("s7_pre_tick", tick, 1);
        load = 1'b1; D = 4'd9;
        step();
        load = 1'b0; start = 1'b0;
        check_eq("s7_Q", Q, 9);
        check_eq("s7_fim", fim, 0);
        check_eq("s7_estado", estado, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
